// File: rtl/serial_bin_adder_if.sv
// Request/result bundle for serial_bin_adder: operands and mode in, result and status out.
interface serial_bin_adder_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (output start, sub, num1, num2, input sum, ovf, busy, done);
    modport slave  (input start, sub, num1, num2, output sum, ovf, busy, done);
endinterface

// File: rtl/serial_bin_adder.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE bits per clock, LSB slice first,
// with carry-out and signed overflow reported on completion.
module serial_bin_adder #(
    parameter int WIDTH          = 4,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    serial_bin_adder_if.slave bus
);
    localparam int BPC   = BITS_PER_CYCLE;
    localparam int STEPS = WIDTH / BPC;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [BPC:0]     full;
    logic             cin_msb;

    function automatic logic [BPC:0] slice_add(input logic [BPC-1:0] x,
                                               input logic [BPC-1:0] y,
                                               input logic           c);
        return {1'b0, x} + {1'b0, y} + {{BPC{1'b0}}, c};
    endfunction

    always_comb begin
        full     = slice_add(a[BPC-1:0], b[BPC-1:0], carry);
        // Carry into the slice's top bit, recovered from that bit's sum and operands.
        cin_msb  = full[BPC-1] ^ a[BPC-1] ^ b[BPC-1];
        res_next = WIDTH'({full[BPC-1:0], res} >> BPC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a        <= '0;
            b        <= '0;
            res      <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            bus.sum  <= '0;
            bus.ovf  <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        // Subtraction is A + ~B + 1, the +1 entering as the initial carry.
                        a        <= bus.num1;
                        b        <= bus.sub ? ~bus.num2 : bus.num2;
                        carry    <= bus.sub;
                        res      <= '0;
                        cnt      <= '0;
                        state    <= RUN;
                        bus.busy <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                RUN: begin
                    a     <= a >> BPC;
                    b     <= b >> BPC;
                    carry <= full[BPC];
                    res   <= res_next;
                    if (cnt == LAST) begin
                        cnt      <= '0;
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.sum  <= {full[BPC], res_next};
                        bus.ovf  <= cin_msb ^ full[BPC];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_bin_adder.sv
// Self-checking bench for serial_bin_adder: directed vectors, multi-cycle corner cases
// and randomized operations against an arithmetic reference model.
module tb_serial_bin_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    serial_bin_adder_if #(.WIDTH(4)) if0 ();
    serial_bin_adder_if #(.WIDTH(8)) if1 ();
    serial_bin_adder_if #(.WIDTH(8)) if2 ();

    serial_bin_adder #(.WIDTH(4), .BITS_PER_CYCLE(1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    serial_bin_adder #(.WIDTH(8), .BITS_PER_CYCLE(2)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    serial_bin_adder #(.WIDTH(8), .BITS_PER_CYCLE(8)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    typedef struct {
        logic [3:0] n1;
        logic [3:0] n2;
        logic       s;
        logic [4:0] exp_sum;
        logic       exp_ovf;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input int id, input logic st, input logic s,
                         input logic [7:0] n1, input logic [7:0] n2);
        case (id)
            0: begin if0.start = st; if0.sub = s; if0.num1 = n1[3:0]; if0.num2 = n2[3:0]; end
            1: begin if1.start = st; if1.sub = s; if1.num1 = n1; if1.num2 = n2; end
            default: begin if2.start = st; if2.sub = s; if2.num1 = n1; if2.num2 = n2; end
        endcase
    endtask

    function automatic logic [8:0] get_sum(input int id);
        case (id)
            0: return {4'b0, if0.sum};
            1: return if1.sum;
            default: return if2.sum;
        endcase
    endfunction

    function automatic logic get_ovf(input int id);
        case (id)
            0: return if0.ovf;
            1: return if1.ovf;
            default: return if2.ovf;
        endcase
    endfunction

    function automatic logic get_busy(input int id);
        case (id)
            0: return if0.busy;
            1: return if1.busy;
            default: return if2.busy;
        endcase
    endfunction

    function automatic logic get_done(input int id);
        case (id)
            0: return if0.done;
            1: return if1.done;
            default: return if2.done;
        endcase
    endfunction

    // Reference: unsigned sum is n1+n2 or n1-n2+2^w; overflow is the signed result leaving range.
    task automatic model(input int w, input longint n1, input longint n2, input logic s,
                         output logic [8:0] rs, output logic ro);
        longint half, sa, sb, r, us;
        half = longint'(1) << (w - 1);
        sa   = (n1 >= half) ? n1 - 2 * half : n1;
        sb   = (n2 >= half) ? n2 - 2 * half : n2;
        r    = s ? sa - sb : sa + sb;
        ro   = (r > half - 1) || (r < -half);
        us   = s ? n1 - n2 + 2 * half : n1 + n2;
        rs   = us[8:0];
    endtask

    task automatic do_op(input int id, input logic [7:0] n1, input logic [7:0] n2, input logic s,
                         output logic [8:0] rs, output logic ro, output int lat, output int bcnt);
        @(negedge clk);
        drive(id, 1'b1, s, n1, n2);
        @(negedge clk);
        drive(id, 1'b0, s, n1, n2);
        lat  = 0;
        bcnt = 0;
        while (!get_done(id) && lat < 40) begin
            if (get_busy(id)) bcnt++;
            @(negedge clk);
            lat++;
        end
        rs = get_sum(id);
        ro = get_ovf(id);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       vecs[9];
        logic [8:0] rs, es;
        logic       ro, eo;
        int         lat, bcnt, w, steps;
        logic [7:0] n1, n2;
        logic       s, seen;

        vecs[0] = '{4'd3,  4'd5,  1'b0, 5'b01000, 1'b1};
        vecs[1] = '{4'd9,  4'd9,  1'b0, 5'b10010, 1'b1};
        vecs[2] = '{4'd0,  4'd0,  1'b0, 5'b00000, 1'b0};
        vecs[3] = '{4'd5,  4'd3,  1'b1, 5'b10010, 1'b0};
        vecs[4] = '{4'd3,  4'd5,  1'b1, 5'b01110, 1'b0};
        vecs[5] = '{4'd8,  4'd1,  1'b1, 5'b10111, 1'b1};
        vecs[6] = '{4'd15, 4'd15, 1'b0, 5'b11110, 1'b0};
        vecs[7] = '{4'd7,  4'd8,  1'b1, 5'b01111, 1'b1};
        vecs[8] = '{4'd4,  4'd5,  1'b0, 5'b01001, 1'b1};

        for (int id = 0; id < 3; id++) drive(id, 1'b0, 1'b0, 8'd0, 8'd0);
        repeat (3) @(negedge clk);
        for (int id = 0; id < 3; id++) begin
            chk($sformatf("reset_sum%0d", id), get_sum(id), 0);
            chk($sformatf("reset_flags%0d", id), {get_ovf(id), get_busy(id), get_done(id)}, 0);
        end
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_op(0, {4'b0, vecs[i].n1}, {4'b0, vecs[i].n2}, vecs[i].s, rs, ro, lat, bcnt);
            chk($sformatf("vec%0d_sum", i), rs, {4'b0, vecs[i].exp_sum});
            chk($sformatf("vec%0d_ovf", i), ro, vecs[i].exp_ovf);
            chk($sformatf("vec%0d_latency", i), lat, 4);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt, 4);
            chk($sformatf("vec%0d_busy_at_done", i), get_busy(0), 0);
        end

        // Start while busy must be ignored.
        @(negedge clk); drive(0, 1'b1, 1'b0, 8'd3, 8'd5);
        @(negedge clk); drive(0, 1'b0, 1'b0, 8'd3, 8'd5);
        @(negedge clk); drive(0, 1'b1, 1'b0, 8'd15, 8'd15);
        @(negedge clk); drive(0, 1'b0, 1'b0, 8'd15, 8'd15);
        lat = 2;
        while (!get_done(0) && lat < 40) begin @(negedge clk); lat++; end
        chk("ignore_latency", lat, 4);
        chk("ignore_sum", get_sum(0), 9'h008);
        chk("ignore_ovf", get_ovf(0), 1);
        @(negedge clk);
        chk("done_pulse_width", get_done(0), 0);
        chk("sum_holds_idle", get_sum(0), 9'h008);

        // Start held through DONE: next op begins with no idle cycle.
        @(negedge clk); drive(0, 1'b1, 1'b0, 8'd3, 8'd5);
        lat = -1;
        while (!get_done(0) && lat < 40) begin @(negedge clk); lat++; end
        chk("b2b_first_latency", lat, 4);
        chk("b2b_first_sum", get_sum(0), 9'h008);
        drive(0, 1'b1, 1'b1, 8'd2, 8'd7);
        @(negedge clk);
        chk("b2b_no_bubble", {get_busy(0), get_done(0)}, 2'b10);
        drive(0, 1'b0, 1'b1, 8'd2, 8'd7);
        lat = 0;
        while (!get_done(0) && lat < 40) begin @(negedge clk); lat++; end
        chk("b2b_second_latency", lat, 4);
        chk("b2b_second_sum", get_sum(0), 9'h00B);
        chk("b2b_second_ovf", get_ovf(0), 0);

        // Reset at step 2 aborts the run and clears the result.
        @(negedge clk); drive(0, 1'b1, 1'b0, 8'd3, 8'd5);
        @(negedge clk); drive(0, 1'b0, 1'b0, 8'd3, 8'd5);
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort_sum", get_sum(0), 0);
        chk("abort_flags", {get_ovf(0), get_busy(0), get_done(0)}, 0);
        seen = 1'b0;
        repeat (6) begin @(negedge clk); if (get_done(0)) seen = 1'b1; end
        chk("abort_no_done", seen, 0);
        do_op(0, 8'd4, 8'd5, 1'b0, rs, ro, lat, bcnt);
        chk("after_abort_sum", rs, 9'h009);
        chk("after_abort_ovf", ro, 1);
        chk("after_abort_latency", lat, 4);

        do_op(1, 8'd200, 8'd100, 1'b0, rs, ro, lat, bcnt);
        chk("w8b2_sum", rs, 9'h12C);
        chk("w8b2_ovf", ro, 0);
        chk("w8b2_latency", lat, 4);
        do_op(2, 8'd127, 8'd1, 1'b0, rs, ro, lat, bcnt);
        chk("w8b8_sum", rs, 9'h080);
        chk("w8b8_ovf", ro, 1);
        chk("w8b8_latency", lat, 1);

        for (int id = 0; id < 3; id++) begin
            w     = (id == 0) ? 4 : 8;
            steps = (id == 2) ? 1 : 4;
            for (int k = 0; k < 30; k++) begin
                n1 = 8'($urandom_range(0, (1 << w) - 1));
                n2 = 8'($urandom_range(0, (1 << w) - 1));
                s  = 1'($urandom % 2);
                model(w, longint'(n1), longint'(n2), s, es, eo);
                do_op(id, n1, n2, s, rs, ro, lat, bcnt);
                chk($sformatf("rand%0d_%0d_sum(%0d%s%0d)", id, k, n1, s ? "-" : "+", n2), rs, es);
                chk($sformatf("rand%0d_%0d_ovf", id, k), ro, eo);
                chk($sformatf("rand%0d_%0d_latency", id, k), lat, steps);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_bin_adder.md
# serial_bin_adder

Parametrised multi-cycle binary adder/subtractor with a start/done handshake, the sequential successor to the combinational 4-bit `bin_adder`. It processes `BITS_PER_CYCLE` bits per clock, LSB slice first, and supports two's-complement subtraction and a signed-overflow flag. It is used where operand width makes a single-cycle ripple adder too slow, or where area matters more than latency.

## Interface
- `WIDTH`, default 4: operand width in bits. Must be ≥ 2.
- `BITS_PER_CYCLE`, default 1: slice width per step. Must divide `WIDTH`.
- `clk`  input  1: rising-edge clock.
- `rst`  input  1: reset, synchronous and active-high.
- `start`  input  1: request. Sampled on `clk` only when the block is not busy.
- `sub`  input  1: mode. 0 = `num1 + num2`; 1 = `num1 - num2`. Latched with `start`.
- `num1`  input  `WIDTH`: operand A. Latched with `start`.
- `num2`  input  `WIDTH`: operand B. Latched with `start`.
- `sum`  output  `WIDTH+1`: result.
  - `sum[WIDTH-1:0]` is the result bits.
  - `sum[WIDTH]` is the final carry-out (for `sub=1`: 1 = no borrow).
- `ovf`  output  1: signed (two's-complement) overflow of the result.
- `busy`  output  1: operation in progress.
- `done`  output  1: one-cycle pulse; result valid.

## Operation
- `STEPS = WIDTH / BITS_PER_CYCLE`.
- States:
  - IDLE: `busy=0`.
  - RUN: `busy=1`, step counter runs 0..`STEPS-1`.
  - DONE: `done=1` for exactly one cycle.
- Transitions:
  - IDLE → RUN on `start`.
  - RUN → DONE after step `STEPS-1`.
  - DONE → RUN on `start`; otherwise DONE → IDLE.
- On accept, the block latches:
  - `A = num1`.
  - `B = sub ? ~num2 : num2`.
  - carry register = `sub`.
- Each RUN cycle:
  - Adds the low `BITS_PER_CYCLE` bits of A and B plus carry.
  - Shifts A and B right by one slice.
  - Shifts the result slice into the MSB end of an internal result register.
  - Updates the carry register.
- Overflow is computed from the MSB slice: `ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1`.
- `sum` and `ovf` update only on the RUN→DONE edge. They hold that value through DONE and IDLE until the next completion. They never show partial results.
- `start` while `busy=1` is ignored: operands and mode are not sampled, and the operation in flight is unaffected.
- `start` asserted during DONE is accepted: back-to-back operations are allowed with no idle bubble.
- Arithmetic is modulo `2^(WIDTH+1)` for add; `sum[WIDTH]` is a true carry. No saturation.

## Timing
- Reset values:
  - `sum=0`, `ovf=0`, `busy=0`, `done=0`.
  - State IDLE, internal carry, counter and shift registers all 0.
- Reset mid-RUN aborts the operation immediately. No `done` is produced, and `sum` is cleared to 0.
- `rst` has priority over `start` in the same cycle.
- Latency, with `start` sampled at edge E0:
  - `busy=1` after E0.
  - Slices are processed at edges E1..E`STEPS`.
  - After E`STEPS`: `busy=0`, `done=1`, `sum`/`ovf` valid.
  - After E`STEPS+1`: `done=0`, unless a new start was accepted at E`STEPS+1`.
- Throughput: one result per `STEPS+1` cycles when `start` is held high.
- `busy` and `done` are never high together.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Default parameters, `num1=3`, `num2=5`, `sub=0`, one-cycle `start` → `done` pulses 4 cycles after the start edge, `sum=5'b01000`, `ovf=1`. `busy` is high for exactly 4 cycles.
- `num1=9`, `num2=9`, `sub=0` → `sum=5'b10010`, `ovf=1`. Also `0+0` → `sum=0`, `ovf=0`.
- `sub=1`:
  - `5-3` → `sum=5'b10010` (`sum[4]=1`, no borrow), `ovf=0`.
  - `3-5` → `sum=5'b01110`, `ovf=0`.
  - `4'b1000 - 1` → `sum[3:0]=4'b0111`, `ovf=1`.
- Re-`start` with `num1=15`, `num2=15` two cycles into a `3+5` run → ignored; result is still `5'b01000` at the original time. `start` held high through DONE → the next op begins with no idle cycle.
- Assert `rst` for one cycle at step 2 of a run → no `done`; `sum=0`, `busy=0`. The next `start` with `4+5` → `sum=5'b01001`, `ovf=1`, latency 4.
- `WIDTH=8`, `BITS_PER_CYCLE=2`, `200+100` → `done` after 4 cycles, `sum=9'h12C`, `ovf=0` (signed -56+100=44). `WIDTH=8`, `BITS_PER_CYCLE=8`, `127+1` → latency 1, `sum=9'h080`, `ovf=1`.
